// File: rtl/issue_batch_fifo_pkg.sv
// issue_batch_fifo_pkg
// Shared constants, width helpers and payload types for the issue batch FIFO.
// Width helpers are functions so the parameterised modules can derive their
// pointer, occupancy and lane-count widths from their own parameter values.
package issue_batch_fifo_pkg;

  localparam int DEF_PORT_NUM   = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  // Widths for the default configuration.
  localparam int DEF_PTR_W   = $clog2(DEF_DEPTH);
  localparam int DEF_COUNT_W = $clog2(DEF_DEPTH) + 1;

  // A lane count ranges over 0..n inclusive, hence the extra bit.
  function automatic int lane_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy ranges over 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [DEF_DATA_WIDTH-1:0] payload_t;
  typedef payload_t [DEF_PORT_NUM-1:0] lane_vec_t;

endpackage

// File: rtl/issue_batch_fifo_count_one.sv
// issue_batch_fifo_count_one
// Counts ones in a lane vector. With CONTINUOUS=1 only the leading run of
// ones starting at bit 0 is counted; the first zero ends the run.
// Ports:
//   vec  in   WIDTH             lane vector
//   cnt  out  $clog2(WIDTH)+1   number of counted ones
module issue_batch_fifo_count_one #(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic [WIDTH-1:0]       vec,
  output logic [$clog2(WIDTH):0] cnt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  always_comb begin
    logic run;
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it holding an old value (which would infer a latch).
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (CONTINUOUS) begin
        run = run & vec[i];
        if (run) cnt = cnt + CNT_W'(1);
      end else if (vec[i]) begin
        cnt = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/issue_batch_fifo.sv
// issue_batch_fifo
// Multi-lane circular buffer between decode and rename/dispatch. Each cycle it
// accepts the leading contiguous run of valid push lanes (capped by free space)
// and retires the leading contiguous run of handshaken pop lanes.
// Build option: define ISSUE_BATCH_FIFO_POP_BYPASS_EN to let slots retired in
// a cycle be refilled at the same edge (adds a pop_ready -> push_accept_cnt
// combinational path).
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   flush            in   synchronous discard of all contents
//   push_data        in   PORT_NUM lanes of DATA_WIDTH payload
//   push_valid       in   per-lane push valid
//   push_accept_cnt  out  lanes 0..n-1 accepted this cycle
//   pop_data         out  lane i = entry at rptr+i
//   pop_valid        out  per-lane entry present
//   pop_ready        in   per-lane consumer ready
//   pop_cnt          out  lanes retired this cycle
//   count            out  registered occupancy
//   full / empty     out  occupancy at DEPTH / zero
module issue_batch_fifo
  import issue_batch_fifo_pkg::*;
#(
  parameter int PORT_NUM   = DEF_PORT_NUM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] push_data,
  input  logic [PORT_NUM-1:0]            push_valid,
  output logic [lane_cnt_width(PORT_NUM)-1:0] push_accept_cnt,
  output logic [PORT_NUM*DATA_WIDTH-1:0] pop_data,
  output logic [PORT_NUM-1:0]            pop_valid,
  input  logic [PORT_NUM-1:0]            pop_ready,
  output logic [lane_cnt_width(PORT_NUM)-1:0] pop_cnt,
  output logic [count_width(DEPTH)-1:0]  count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int LW = lane_cnt_width(PORT_NUM);
  // One extra bit so count arithmetic cannot overflow before truncation.
  localparam int FW = CW + 1;

  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]       push_run, pop_run;
  logic [PORT_NUM-1:0] pop_hs;
  logic [FW-1:0]       free;

  assign pop_hs = pop_valid & pop_ready;

  issue_batch_fifo_count_one #(.WIDTH(PORT_NUM), .CONTINUOUS(1'b1)) u_push_run (
    .vec (push_valid),
    .cnt (push_run)
  );

  issue_batch_fifo_count_one #(.WIDTH(PORT_NUM), .CONTINUOUS(1'b1)) u_pop_run (
    .vec (pop_hs),
    .cnt (pop_run)
  );

`ifdef ISSUE_BATCH_FIFO_POP_BYPASS_EN
  assign free = FW'(DEPTH) - FW'(count_q) + FW'(pop_run);
`else
  assign free = FW'(DEPTH) - FW'(count_q);
`endif

  // Both counts are held at zero while reset or flush is asserted so the
  // producer and consumer never see a handshake that will be discarded.
  always_comb begin
    push_accept_cnt = '0;
    pop_cnt         = '0;
    if (!(rst || flush)) begin
      pop_cnt = pop_run;
      // free <= push_run here, so truncating free to LW bits is lossless.
      push_accept_cnt = (FW'(push_run) < free) ? push_run : LW'(free);
    end
  end

  // Lane i of the read window is the entry at rptr+i; pointers wrap mod DEPTH.
  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      pop_valid[i] = count_q > CW'(i);
      pop_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rptr + PW'(i)];
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      wptr    <= wptr + PW'(push_accept_cnt);
      rptr    <= rptr + PW'(pop_cnt);
      count_q <= CW'(FW'(count_q) + FW'(push_accept_cnt) - FW'(pop_cnt));
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (LW'(i) < push_accept_cnt)
        mem[wptr + PW'(i)] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_issue_batch_fifo.sv
// tb_issue_batch_fifo
// Self-checking bench for issue_batch_fifo. A queue-based reference model
// tracks the FIFO contents; every cycle the DUT's combinational and
// registered outputs are compared with values derived from that queue.
module tb_issue_batch_fifo;
  import issue_batch_fifo_pkg::*;

  localparam int P  = 4;
  localparam int DW = 32;
  localparam int D  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [P*DW-1:0] push_data = '0;
  logic [P-1:0]    push_valid = '0;
  logic [P-1:0]    pop_ready = '0;
  logic [2:0]      push_accept_cnt;
  logic [2:0]      pop_cnt;
  logic [P*DW-1:0] pop_data;
  logic [P-1:0]    pop_valid;
  logic [4:0]      count;
  logic            full;
  logic            empty;

  int checks = 0;
  int passes = 0;
  int obs_acc;
  int obs_pop;
  payload_t model_q[$];

  issue_batch_fifo #(.PORT_NUM(P), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .push_data       (push_data),
    .push_valid      (push_valid),
    .push_accept_cnt (push_accept_cnt),
    .pop_data        (pop_data),
    .pop_valid       (pop_valid),
    .pop_ready       (pop_ready),
    .pop_cnt         (pop_cnt),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  // Number of consecutive ones starting at lane 0.
  function automatic int lead_run(input logic [P-1:0] v);
    int n = 0;
    while (n < P && v[n]) n++;
    return n;
  endfunction

  // One cycle: drive inputs, compare at the falling edge, advance the model
  // at the rising edge. Called just after a rising edge.
  task automatic cycle(input logic [P-1:0] pv, input logic [P-1:0] pr, input logic fl);
    logic [P*DW-1:0] pd;
    logic [P-1:0]    hs;
    logic [P-1:0]    exp_pv;
    int sz, free, acc, pops;
    for (int i = 0; i < P; i++) pd[i*DW +: DW] = $urandom;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
    @(negedge clk);
    sz = model_q.size();
    for (int i = 0; i < P; i++) begin
      exp_pv[i] = (i < sz);
      hs[i]     = (i < sz) && pr[i];
    end
    pops = fl ? 0 : lead_run(hs);
    free = D - sz;
`ifdef ISSUE_BATCH_FIFO_POP_BYPASS_EN
    free = free + pops;
`endif
    acc = fl ? 0 : ((lead_run(pv) < free) ? lead_run(pv) : free);

    checks++;
    if (push_accept_cnt !== 3'(acc))
      $display("FAIL accept_cnt: got %0d expected %0d (t=%0t)", push_accept_cnt, acc, $time);
    else passes++;
    checks++;
    if (pop_cnt !== 3'(pops))
      $display("FAIL pop_cnt: got %0d expected %0d (t=%0t)", pop_cnt, pops, $time);
    else passes++;
    checks++;
    if (count !== 5'(sz) || full !== (sz == D) || empty !== (sz == 0))
      $display("FAIL occupancy: got count=%0d full=%b empty=%b expected count=%0d (t=%0t)",
               count, full, empty, sz, $time);
    else passes++;
    checks++;
    if (pop_valid !== exp_pv)
      $display("FAIL pop_valid: got %b expected %b (t=%0t)", pop_valid, exp_pv, $time);
    else passes++;
    for (int i = 0; i < P && i < sz; i++) begin
      checks++;
      if (pop_data[i*DW +: DW] !== model_q[i])
        $display("FAIL pop_data lane %0d: got %h expected %h (t=%0t)",
                 i, pop_data[i*DW +: DW], model_q[i], $time);
      else passes++;
    end
    obs_acc = int'(push_accept_cnt);
    obs_pop = int'(pop_cnt);

    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      repeat (pops) void'(model_q.pop_front());
      for (int i = 0; i < acc; i++) model_q.push_back(pd[i*DW +: DW]);
    end
    #1;
    flush      = 1'b0;
    push_valid = '0;
    pop_ready  = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && model_q.size() != 0; k++) cycle(4'b0000, 4'b1111, 1'b0);
  endtask

  task automatic test_reset();
    push_valid = 4'b1111;
    pop_ready  = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
    else passes++;
    checks++;
    if (pop_valid !== 4'b0000 || push_accept_cnt !== 3'd0 || pop_cnt !== 3'd0)
      $display("FAIL reset_lanes: got pop_valid=%b accept=%0d pop_cnt=%0d expected 0/0/0",
               pop_valid, push_accept_cnt, pop_cnt);
    else passes++;
    rst        = 1'b0;
    push_valid = '0;
    pop_ready  = '0;
    model_q.delete();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      checks++;
      if (obs_acc != 4) $display("FAIL fill_accept: got %0d expected 4", obs_acc);
      else passes++;
    end
    checks++;
    if (count !== 5'd16 || full !== 1'b1)
      $display("FAIL fill_full: got count=%0d full=%b expected 16/1", count, full);
    else passes++;
    cycle(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (obs_acc != 0) $display("FAIL full_accept: got %0d expected 0", obs_acc);
    else passes++;
    drain();
  endtask

  task automatic test_gap();
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1011, 4'b0000, 1'b0);
    checks++;
    if (obs_acc != 2) $display("FAIL gap_accept: got %0d expected 2", obs_acc);
    else passes++;
    checks++;
    if (count !== 5'd2 || pop_valid !== 4'b0011)
      $display("FAIL gap_state: got count=%0d pop_valid=%b expected 2/0011", count, pop_valid);
    else passes++;
    drain();
  endtask

  task automatic test_simultaneous();
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0011, 4'b0000, 1'b0);
    checks++;
    if (count !== 5'd14) $display("FAIL simul_setup: got count=%0d expected 14", count);
    else passes++;
    cycle(4'b1111, 4'b1111, 1'b0);
`ifdef ISSUE_BATCH_FIFO_POP_BYPASS_EN
    checks++;
    if (obs_acc != 4 || obs_pop != 4 || count !== 5'd14)
      $display("FAIL simul: got accept=%0d pop=%0d count=%0d expected 4/4/14", obs_acc, obs_pop, count);
    else passes++;
`else
    checks++;
    if (obs_acc != 2 || obs_pop != 4 || count !== 5'd12)
      $display("FAIL simul: got accept=%0d pop=%0d count=%0d expected 2/4/12", obs_acc, obs_pop, count);
    else passes++;
`endif
    drain();
  endtask

  task automatic test_wrap();
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0011, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0000, 4'b0011, 1'b0);
    // Both pointers now sit at 14; the next four lanes straddle 15 -> 0.
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b0);
    checks++;
    if (obs_pop != 4 || count !== 5'd0)
      $display("FAIL wrap_pop: got pop=%0d count=%0d expected 4/0", obs_pop, count);
    else passes++;
    // Read pointer is now 2: a single entry must come back from slot 2.
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0001, 1'b0);
  endtask

  task automatic test_partial_pop();
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0111, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b1101, 1'b0);
    checks++;
    if (obs_pop != 1 || count !== 5'd2)
      $display("FAIL partial_pop: got pop=%0d count=%0d expected 1/2", obs_pop, count);
    else passes++;
    drain();
  endtask

  task automatic test_flush_reset();
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    checks++;
    if (count !== 5'd9) $display("FAIL flush_setup: got count=%0d expected 9", count);
    else passes++;
    cycle(4'b1111, 4'b1111, 1'b1);
    checks++;
    if (obs_acc != 0 || obs_pop != 0 || count !== 5'd0 || empty !== 1'b1)
      $display("FAIL flush: got accept=%0d pop=%0d count=%0d empty=%b expected 0/0/0/1",
               obs_acc, obs_pop, count, empty);
    else passes++;
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    push_valid = 4'b1111;
    pop_ready  = 4'b1111;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 4'b0000 ||
        push_accept_cnt !== 3'd0 || pop_cnt !== 3'd0)
      $display("FAIL midstream_reset: got count=%0d empty=%b full=%b pop_valid=%b accept=%0d pop=%0d",
               count, empty, full, pop_valid, push_accept_cnt, pop_cnt);
    else passes++;
    model_q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    push_valid = '0;
    pop_ready  = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [P-1:0] pv, pr;
      pv = (k % 3 == 0) ? 4'b1111 : P'($urandom);
      pr = (k % 5 == 0) ? 4'b1111 : P'($urandom);
      cycle(pv, pr, ($urandom_range(0, 39) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gap();
    test_simultaneous();
    test_wrap();
    test_partial_pop();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/issue_batch_fifo.md
Name: issue_batch_fifo

Overview:
- Multi-lane circular buffer with PORT_NUM push lanes and PORT_NUM pop lanes.
- Used between decode and rename/dispatch.
- Each cycle it accepts the leading contiguous run of valid push lanes, capped by free space.
- Each cycle it retires the leading contiguous run of handshaken pop lanes.
- Both lane counts come from count_one in CONTINUOUS mode; this block sequences pointers, occupancy and lane masks around them.

Parameters:
- PORT_NUM, 4, number of push lanes and number of pop lanes; 1..DEPTH.
- DATA_WIDTH, 32, payload bits per lane.
- DEPTH, 16, number of entries; power of two, DEPTH >= PORT_NUM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- push_data  in  PORT_NUM*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- push_valid  in  PORT_NUM  lane i carries a valid entry.
- push_accept_cnt  out  $clog2(PORT_NUM)+1  lanes 0..n-1 accepted this cycle (combinational).
- pop_data  out  PORT_NUM*DATA_WIDTH  lane i = entry at rptr+i.
- pop_valid  out  PORT_NUM  lane i holds a valid entry.
- pop_ready  in  PORT_NUM  consumer can take lane i.
- pop_cnt  out  $clog2(PORT_NUM)+1  lanes retired this cycle (combinational).
- count  out  $clog2(DEPTH)+1  current occupancy (registered).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- State registers: wptr and rptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register; storage array (not reset).
- Reset (async, rst=1):
  - wptr=rptr=count=0.
  - empty=1, full=0.
  - pop_valid=0, push_accept_cnt=0, pop_cnt=0.
- push_run = count_one(CONTINUOUS=1) of push_valid, i.e. leading contiguous ones.
  - A gap drops every lane after it; the producer re-presents those lanes next cycle.
- free = DEPTH - count.
- push_accept_cnt = min(push_run, free).
  - Accepted lane i is written to storage[(wptr+i) mod DEPTH].
- pop_valid[i] = (i < count).
- pop_data lane i = storage[(rptr+i) mod DEPTH]. Read is combinational; pop_data is don't-care where pop_valid=0.
- pop_cnt = count_one(CONTINUOUS=1) of (pop_valid & pop_ready).
  - Lanes after the first non-handshaken lane are not retired, even when ready.
- Edge update when not flushing:
  - wptr += push_accept_cnt.
  - rptr += pop_cnt.
  - count += push_accept_cnt - pop_cnt.
  - Width: compute in $clog2(DEPTH)+2 bits, then truncate.
- Latency: an entry pushed at edge t appears on pop_valid/pop_data during the cycle after t.
- No push-to-pop bypass; an empty FIFO never pops same-cycle pushes.
- Simultaneous push and pop: both applied. free uses pre-pop count (see optional feature).
- Full: push_accept_cnt=0; pop operates normally.
- Empty: pop_valid=0, pop_cnt=0; push operates normally.
- Wrap-around: lanes straddling DEPTH-1 → 0 must read/write correctly for both pointers.
- flush=1:
  - At the next edge wptr=rptr=count=0; pushes and pops that cycle are discarded.
  - push_accept_cnt and pop_cnt are forced to 0 during the flush cycle.
- Reset asserted mid-operation: immediate return to reset state; storage contents are irrelevant.

Optional Feature:
- Macro: ISSUE_BATCH_FIFO_POP_BYPASS_EN.
- Defined: free = DEPTH - count + pop_cnt, so slots retired this cycle can be refilled at the same edge. This creates a combinational path pop_ready → push_accept_cnt.
- Undefined: free = DEPTH - count; no pop_ready → push path.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package (issue_batch_fifo_pkg) holds:
  - Lane-count width function/constant.
  - Pointer and count width constants derived from DEPTH.
  - Typedef for the per-lane payload vector.
- Sub-module: two count_one instances with CONTINUOUS=1, WIDTH=PORT_NUM. One takes push_valid; the other takes pop_valid & pop_ready.
- No further sub-modules.

Test Plan:
1. Reset, then push_valid=4'b1111, pop_ready=0 for 4 cycles → push_accept_cnt=4 each cycle; count=16, full=1; fifth cycle push_accept_cnt=0.
2. push_valid=4'b1011 into empty FIFO → push_accept_cnt=2, count=2; next cycle pop_valid=4'b0011.
3. count=14, push_valid=4'b1111, pop_ready=4'b1111 → bypass undefined: accept=2, pop=4, count=12. Defined: accept=4, count=14.
4. wptr=rptr=14, push 4 lanes, then pop_ready=4'b1111 → data returned in order across the 15→0 wrap; rptr=2.
5. count=3, pop_ready=4'b1101 → pop_cnt=1, count=2; lane 2 is not retired.
6. count=9, flush=1 with push_valid=4'b1111 → push_accept_cnt=0; next cycle count=0, empty=1. Then rst pulsed mid-stream → outputs return to reset values immediately.
